// File: rtl/seq_mult_unit.sv
// seq_mult_unit: sequential shift-add multiplier, one multiplier bit per cycle.
// Works on operand magnitudes and applies the product sign once on completion.
// Ends early when the remaining multiplier bits are zero; a zero operand skips RUN.
// valid/ready handshakes on the operand side and on the result side.
module seq_mult_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     cycles,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic            is_signed);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (is_signed && (sv < 0))
            return ~v + 1'b1;
        return v;
    endfunction

    // Restore the product sign. |A|*|B| <= 2^(2*WIDTH-2), so the negation is exact.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                 input logic          neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;

    logic             accept;
    logic             zero_op;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_step;
    logic [WIDTH-1:0] mplier_step;
    logic [CNT_W-1:0] cnt_step;
    logic             run_last;

    assign accept      = start_valid && start_ready;
    assign zero_op     = (multiplicand == '0) || (multiplier == '0);
    assign partial     = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    assign acc_step    = acc_q + partial;
    assign mplier_step = mplier_q >> 1;
    assign cnt_step    = cnt_q + 1'b1;
    // Finished once no set multiplier bits remain or every bit position was visited.
    assign run_last    = (mplier_step == '0) || (cnt_step == CNT_W'(WIDTH));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; an accept in DONE chains the next operation with no bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = zero_op ? DONE : RUN;
            end
            RUN: begin
                if (run_last)
                    state_nxt = DONE;
            end
            DONE: begin
                if (accept)
                    state_nxt = zero_op ? DONE : RUN;
                else if (result_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs, decoded from the current state.
    always_comb begin
        start_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: start_ready = 1'b1;
            RUN:  busy        = 1'b1;
            DONE: begin
                result_valid = 1'b1;
                start_ready  = result_ready;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Working registers: loaded on accept, stepped once per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand_q  <= magnitude(multiplicand, signed_mode);
            mplier_q <= magnitude(multiplier, signed_mode);
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= signed_mode && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        end else if (state == RUN) begin
            acc_q    <= acc_step;
            mplier_q <= mplier_step;
            cnt_q    <= cnt_step;
        end
    end

    // Result registers: written only when an operation completes, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            product <= '0;
            cycles  <= '0;
        end else if (accept && zero_op) begin
            product <= '0;
            cycles  <= '0;
        end else if ((state == RUN) && run_last) begin
            product <= apply_sign(acc_step, neg_q);
            cycles  <= cnt_step;
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit at WIDTH = 8 with hand-computed expectations.
module tb_seq_mult_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start_valid = 1'b0;
    logic               start_ready;
    logic [WIDTH-1:0]   multiplicand = '0;
    logic [WIDTH-1:0]   multiplier = '0;
    logic               signed_mode = 1'b0;
    logic               result_valid;
    logic               result_ready = 1'b0;
    logic [2*WIDTH-1:0] product;
    logic [CNT_W-1:0]   cycles;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int lat;

    seq_mult_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .cycles       (cycles),
        .busy         (busy)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one operand pair and return #1 after the accepting edge.
    task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic s, input string tag);
        int n;
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        start_valid  = 1'b1;
        n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    // Cycles from accept (accept cycle = 0) until result_valid is observed.
    task automatic wait_valid(output int n, input string tag);
        n = 1;
        while (!result_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    initial begin
        // Reset state, both during and after reset.
        #12;
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_start_ready",  32'(start_ready),  32'd1);
        chk("rst_product",      32'(product),      32'd0);
        chk("rst_cycles",       32'(cycles),       32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_start_ready", 32'(start_ready), 32'd1);

        // 13 x 11 unsigned: 11 = 1011b, four RUN cycles.
        accept_op(8'd13, 8'd11, 1'b0, "u13x11");
        chk("u13x11_busy", 32'(busy), 32'd1);
        wait_valid(lat, "u13x11");
        chk("u13x11_latency", 32'(lat),     32'd5);
        chk("u13x11_product", 32'(product), 32'h008F);
        chk("u13x11_cycles",  32'(cycles),  32'd4);
        chk("u13x11_busy_dn", 32'(busy),    32'd0);
        take_result();
        chk("u13x11_valid_after", 32'(result_valid), 32'd0);
        chk("u13x11_persist",     32'(product),      32'h008F);
        chk("u13x11_ready_after", 32'(start_ready),  32'd1);

        // -3 x 5 signed: magnitudes 3 and 5, three RUN cycles, product -15.
        accept_op(8'hFD, 8'd5, 1'b1, "s_m3x5");
        wait_valid(lat, "s_m3x5");
        chk("s_m3x5_latency", 32'(lat),     32'd4);
        chk("s_m3x5_product", 32'(product), 32'hFFF1);
        chk("s_m3x5_cycles",  32'(cycles),  32'd3);
        take_result();

        // -128 x -128 signed: magnitude 128 each, full eight RUN cycles.
        accept_op(8'h80, 8'h80, 1'b1, "s_ext");
        wait_valid(lat, "s_ext");
        chk("s_ext_latency", 32'(lat),     32'd9);
        chk("s_ext_product", 32'(product), 32'h4000);
        chk("s_ext_cycles",  32'(cycles),  32'd8);
        take_result();

        // 0 x 200: straight to DONE, RUN never entered.
        accept_op(8'd0, 8'd200, 1'b0, "zero");
        chk("zero_busy",    32'(busy),         32'd0);
        chk("zero_valid",   32'(result_valid), 32'd1);
        chk("zero_product", 32'(product),      32'd0);
        chk("zero_cycles",  32'(cycles),       32'd0);
        take_result();

        // 7 x 1 then backpressure with a competing offer that must be ignored.
        accept_op(8'd7, 8'd1, 1'b0, "u7x1");
        wait_valid(lat, "u7x1");
        chk("u7x1_latency", 32'(lat),     32'd2);
        chk("u7x1_product", 32'(product), 32'd7);
        chk("u7x1_cycles",  32'(cycles),  32'd1);
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        start_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_product",     32'(product),      32'd7);
            chk("hold_start_ready", 32'(start_ready),  32'd0);
            chk("hold_valid",       32'(result_valid), 32'd1);
        end
        // Result handshake and new accept on the same edge.
        multiplicand = 8'd2;
        multiplier   = 8'd2;
        result_ready = 1'b1;
        #1;
        chk("b2b_start_ready", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        chk("b2b_busy",    32'(busy),         32'd1);
        chk("b2b_valid",   32'(result_valid), 32'd0);
        chk("b2b_persist", 32'(product),      32'd7);
        wait_valid(lat, "b2b");
        chk("b2b_latency", 32'(lat),     32'd3);
        chk("b2b_product", 32'(product), 32'd4);
        chk("b2b_cycles",  32'(cycles),  32'd2);
        take_result();

        // Reset during the third RUN cycle of 255 x 255.
        accept_op(8'd255, 8'd255, 1'b0, "rst_mid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_valid",       32'(result_valid), 32'd0);
        chk("rst_mid_product",     32'(product),      32'd0);
        chk("rst_mid_start_ready", 32'(start_ready),  32'd1);
        chk("rst_mid_busy",        32'(busy),         32'd0);
        chk("rst_mid_cycles",      32'(cycles),       32'd0);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        accept_op(8'd255, 8'd255, 1'b0, "u255");
        wait_valid(lat, "u255");
        chk("u255_latency", 32'(lat),     32'd9);
        chk("u255_product", 32'(product), 32'hFE01);
        chk("u255_cycles",  32'(cycles),  32'd8);
        take_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
